spi_cmd_master: RTL and testbench

Initiator end of the register-access SPI protocol. Accepts one register access request at a time (read/write, high/low select, 6-bit address, write data) and encodes it into the two-byte command stream. Drives SPI mode 0 (CPOL=0, CPHA=0, MSB first) on SCLK/MOSI/CS_N. For reads, it clocks one extra byte to collect the response. It sits in the test/host-side fabric and exercises the PWM peripheral's SPI slave and instruction decoder.

---
 rtl/spi_cmd_pkg.sv | 19 +
 rtl/spi_cmd_master_shifter.sv | 38 +++
 rtl/spi_cmd_master.sv | 116 +++++++++++
 tb/tb_spi_cmd_master.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_cmd_pkg.sv
// spi_cmd_pkg: shared state encoding, command-byte field positions and byte counts
// for the register-access SPI command master.
package spi_cmd_pkg;
    typedef enum logic [2:0] {IDLE, CS_SETUP, SHIFT, GAP, CS_HOLD, DONE} state_t;
    localparam int RW_BIT = 7;
    localparam int HL_BIT = 6;
    localparam int ADDR_W = 6;
    localparam logic [7:0] DUMMY_BYTE = 8'h00;
    localparam int WR_BYTES = 2;
    localparam int RD_BYTES = 3;
    function automatic logic [7:0] cmd_byte(input logic rw, input logic hl, input logic [ADDR_W-1:0] addr);
        logic [7:0] b;
        b = '0;
        b[RW_BIT] = rw;
        b[HL_BIT] = hl;
        b[ADDR_W-1:0] = addr;
        return b;
    endfunction
endpackage

// File: rtl/spi_cmd_master_shifter.sv
// spi_byte_shifter: one-byte MOSI/MISO shift register with a 7->0 bit counter,
// stepped by divider edge strobes from the parent FSM.
module spi_byte_shifter (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [7:0] load_data,
    input  logic       rise_stb,
    input  logic       fall_stb,
    input  logic       miso,
    output logic       mosi,
    output logic       last_bit,
    output logic [7:0] rx_data
);
    logic [7:0] tx_sr;
    logic [2:0] bit_cnt;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_sr   <= '0;
            rx_data <= '0;
            bit_cnt <= '0;
            mosi    <= 1'b0;
        end else begin
            if (rise_stb) rx_data <= {rx_data[6:0], miso};
            // a load on the last falling edge puts the next byte's MSB on the wire immediately
            if (load) begin
                tx_sr   <= load_data;
                mosi    <= load_data[7];
                bit_cnt <= 3'd7;
            end else if (fall_stb) begin
                tx_sr   <= {tx_sr[6:0], 1'b0};
                mosi    <= tx_sr[6];
                bit_cnt <= bit_cnt - 3'd1;
            end
        end
    end
    assign last_bit = bit_cnt == 3'd0;
endmodule

// File: rtl/spi_cmd_master.sv
// spi_cmd_master: encodes one register access into the SPI mode-0 command stream
// (setup byte, data byte, plus a dummy byte for reads that returns the read data).
module spi_cmd_master #(
    parameter int CLK_DIV = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_write,
    input  logic       req_hl,
    input  logic [5:0] req_addr,
    input  logic [7:0] req_wdata,
    output logic       rsp_valid,
    output logic [7:0] rsp_rdata,
    output logic       busy,
    output logic       sclk,
    output logic       cs_n,
    output logic       mosi,
    input  logic       miso
);
    import spi_cmd_pkg::*;
    localparam int DW = $clog2(CLK_DIV + 1);
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    state_t state, state_d;
    logic [DW-1:0] div_cnt, div_cnt_d;
    logic [1:0] byte_idx, byte_idx_d, nxt_idx;
    logic gap_ph, gap_ph_d;
    logic wr_q;
    logic [7:0] wdata_q, load_data, rx_data;
    logic accept, div_end, rise_stb, fall_stb, load, last_bit, more_bytes;
    assign accept  = req_valid && req_ready;
    assign div_end = div_cnt == '0;
    spi_byte_shifter u_shifter (
        .clk(clk), .rst_n(rst_n), .load(load), .load_data(load_data),
        .rise_stb(rise_stb), .fall_stb(fall_stb), .miso(miso),
        .mosi(mosi), .last_bit(last_bit), .rx_data(rx_data)
    );
    // GAP spans the final low half of a byte plus one extra half-period, tracked by gap_ph
    always_comb begin
        state_d    = state;
        div_cnt_d  = div_end ? DIV_LAST : div_cnt - DW'(1);
        byte_idx_d = byte_idx;
        gap_ph_d   = gap_ph;
        rise_stb   = 1'b0;
        fall_stb   = 1'b0;
        load       = 1'b0;
        load_data  = DUMMY_BYTE;
        nxt_idx    = byte_idx + 2'd1;
        more_bytes = int'(nxt_idx) < (wr_q ? WR_BYTES : RD_BYTES);
        case (state)
            IDLE: if (accept) begin
                state_d    = CS_SETUP;
                div_cnt_d  = DIV_LAST;
                byte_idx_d = 2'd0;
                gap_ph_d   = 1'b0;
                load       = 1'b1;
                load_data  = cmd_byte(req_write, req_hl, req_addr);
            end
            CS_SETUP: if (div_end) begin
                state_d  = SHIFT;
                rise_stb = 1'b1;
            end
            SHIFT: if (div_end) begin
                rise_stb = !sclk;
                fall_stb = sclk;
                if (sclk && last_bit) begin
                    byte_idx_d = nxt_idx;
                    load       = 1'b1;
                    load_data  = (nxt_idx == 2'd1 && wr_q) ? wdata_q : DUMMY_BYTE;
                    state_d    = more_bytes ? GAP : CS_HOLD;
                end
            end
            GAP: if (div_end) begin
                gap_ph_d = !gap_ph;
                rise_stb = gap_ph;
                state_d  = gap_ph ? SHIFT : GAP;
            end
            CS_HOLD: if (div_end) state_d = DONE;
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            div_cnt   <= '0;
            byte_idx  <= '0;
            gap_ph    <= 1'b0;
            wr_q      <= 1'b0;
            wdata_q   <= '0;
            req_ready <= 1'b1;
            busy      <= 1'b0;
            cs_n      <= 1'b1;
            sclk      <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            state    <= state_d;
            div_cnt  <= div_cnt_d;
            byte_idx <= byte_idx_d;
            gap_ph   <= gap_ph_d;
            if (accept) begin
                wr_q    <= req_write;
                wdata_q <= req_wdata;
            end
            req_ready <= state_d == IDLE;
            busy      <= state_d != IDLE;
            cs_n      <= state_d inside {IDLE, DONE};
            rsp_valid <= state_d == DONE;
            if (rise_stb) sclk <= 1'b1;
            else if (fall_stb) sclk <= 1'b0;
            if (state_d == DONE && !wr_q) rsp_rdata <= rx_data;
        end
    end
endmodule

// File: tb/tb_spi_cmd_master.sv
// tb_spi_cmd_master: randomized self-checking bench for spi_cmd_master with one DUT per
// CLK_DIV value (1..4), a bus monitor, a mode-0 slave model and a byte-level reference model.
module tb_spi_cmd_master;
    logic clk = 1'b0;
    logic rst_n;
    logic req_valid, req_write, req_hl, loop_en;
    logic [5:0] req_addr;
    logic [7:0] req_wdata;
    logic [1:0] sel;
    logic [3:0] rdy_v, rspv_v, busy_v, sclk_v, csn_v, mosi_v;
    logic [7:0] rdata_v [4];
    logic [23:0] slv_word;
    int slv_cnt;
    logic slv_miso;
    int checks = 0, errors = 0;
    logic [7:0] exp_rd [4];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        spi_cmd_master #(.CLK_DIV(g + 1)) dut (
            .clk(clk), .rst_n(rst_n), .req_valid(req_valid && sel == g), .req_ready(rdy_v[g]),
            .req_write(req_write), .req_hl(req_hl), .req_addr(req_addr), .req_wdata(req_wdata),
            .rsp_valid(rspv_v[g]), .rsp_rdata(rdata_v[g]), .busy(busy_v[g]), .sclk(sclk_v[g]),
            .cs_n(csn_v[g]), .mosi(mosi_v[g]), .miso(loop_en ? mosi_v[g] : slv_miso)
        );
    end

    wire cur_rdy = rdy_v[sel], cur_rspv = rspv_v[sel], cur_busy = busy_v[sel];
    wire cur_sclk = sclk_v[sel], cur_csn = csn_v[sel], cur_mosi = mosi_v[sel];
    wire [7:0] cur_rdata = rdata_v[sel];
    assign slv_miso = (slv_cnt < 24) ? slv_word[23 - slv_cnt] : 1'b0;

    // bus monitor and mode-0 slave: everything observed half a cycle after the DUT's edge
    logic mosi_bits[$];
    int rise_t[$], hi_lens[$], cs_fall_t[$], cs_rise_t[$];
    int cyc = 0, hi_run = 0, cs_low_cyc = 0, busy_cyc = 0, rsp_cnt = 0, rdy_busy_err = 0, mode0_err = 0;
    logic prev_sclk = 1'b0, prev_csn = 1'b1, prev_mosi = 1'b0;
    always @(negedge clk) begin
        cyc++;
        if (cur_sclk && !prev_sclk) begin
            mosi_bits.push_back(cur_mosi);
            rise_t.push_back(cyc);
            hi_run = 0;
        end
        if (cur_sclk) hi_run++;
        if (!cur_sclk && prev_sclk) hi_lens.push_back(hi_run);
        if (!cur_csn) cs_low_cyc++;
        if (cur_busy) busy_cyc++;
        if (cur_rspv) rsp_cnt++;
        if (cur_rdy && cur_busy) rdy_busy_err++;
        if (prev_csn && !cur_csn) cs_fall_t.push_back(cyc);
        if (!prev_csn && cur_csn) cs_rise_t.push_back(cyc);
        if (cur_csn != prev_csn && (cur_sclk || prev_sclk)) mode0_err++;
        if (!cur_csn && !prev_csn && cur_mosi != prev_mosi && !(prev_sclk && !cur_sclk)) mode0_err++;
        if (cur_csn) slv_cnt = 0;
        else if (prev_sclk && !cur_sclk) slv_cnt++;
        prev_sclk = cur_sclk;
        prev_csn  = cur_csn;
        prev_mosi = cur_mosi;
    end

    // reference model: the command stream as bytes, right-justified (16 bits for writes, 24 for reads)
    function automatic logic [23:0] exp_stream(input logic wr, input logic hl, input logic [5:0] a, input logic [7:0] wd);
        return wr ? {8'h00, 1'b1, hl, a, wd} : {1'b0, hl, a, 16'h0000};
    endfunction

    function automatic int exp_cs_low(input int div, input logic wr);
        return div * (wr ? 1 + 32 + 1 : 1 + 48 + 2);
    endfunction

    task automatic wait_rsp(output logic [7:0] rd, output bit to);
        to = 1'b1;
        rd = '0;
        for (int n = 0; n < 400; n++) begin
            if (cur_rspv) begin
                to = 1'b0;
                rd = cur_rdata;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic run_xfer(input logic wr, input logic hl, input logic [5:0] a, input logic [7:0] wd,
                            output logic [23:0] obs, output int nb, output int csl, output int bc,
                            output int np, output logic [7:0] rd, output bit to);
        int b0, c0, p0, k0;
        b0 = mosi_bits.size();
        c0 = cs_low_cyc;
        p0 = rsp_cnt;
        k0 = busy_cyc;
        req_valid = 1'b1;
        req_write = wr;
        req_hl    = hl;
        req_addr  = a;
        req_wdata = wd;
        @(negedge clk);
        req_valid = 1'b0;
        req_write = 1'($urandom);
        req_hl    = 1'($urandom);
        req_addr  = 6'($urandom);
        req_wdata = 8'($urandom);
        wait_rsp(rd, to);
        @(negedge clk);
        @(negedge clk);
        obs = '0;
        nb  = mosi_bits.size() - b0;
        for (int i = b0; i < mosi_bits.size() && i < b0 + 24; i++) obs = {obs[22:0], mosi_bits[i]};
        csl = cs_low_cyc - c0;
        bc  = busy_cyc - k0;
        np  = rsp_cnt - p0;
    endtask

    task automatic test_reset();
        for (int pass = 0; pass < 2; pass++) begin
            checks++; if (csn_v !== 4'hF) begin errors++; $display("FAIL reset_cs_n: got %b expected 1111", csn_v); end
            checks++; if (sclk_v !== 4'h0) begin errors++; $display("FAIL reset_sclk: got %b expected 0000", sclk_v); end
            checks++; if (mosi_v !== 4'h0) begin errors++; $display("FAIL reset_mosi: got %b expected 0000", mosi_v); end
            checks++; if (rspv_v !== 4'h0) begin errors++; $display("FAIL reset_rsp_valid: got %b expected 0000", rspv_v); end
            checks++; if (busy_v !== 4'h0) begin errors++; $display("FAIL reset_busy: got %b expected 0000", busy_v); end
            checks++; if (rdy_v !== 4'hF) begin errors++; $display("FAIL reset_req_ready: got %b expected 1111", rdy_v); end
            checks++; if ({rdata_v[0], rdata_v[1], rdata_v[2], rdata_v[3]} !== 32'h0) begin
                errors++; $display("FAIL reset_rsp_rdata: got %h %h %h %h expected 00", rdata_v[0], rdata_v[1], rdata_v[2], rdata_v[3]);
            end
            rst_n = 1'b1;
            @(negedge clk);
            @(negedge clk);
        end
    endtask

    task automatic test_write_div1();
        logic [23:0] obs; int nb, csl, bc, np; logic [7:0] rd; bit to;
        sel = 2'd0;
        run_xfer(1'b1, 1'b0, 6'h05, 8'hA5, obs, nb, csl, bc, np, rd, to);
        checks++; if (to) begin errors++; $display("FAIL wr1_timeout: rsp_valid not seen within 400 cycles"); end
        checks++; if (nb !== 16 || obs !== exp_stream(1'b1, 1'b0, 6'h05, 8'hA5)) begin
            errors++; $display("FAIL wr1_mosi: got %0d bits %h expected 16 bits %h", nb, obs, exp_stream(1'b1, 1'b0, 6'h05, 8'hA5));
        end
        checks++; if (csl !== exp_cs_low(1, 1'b1)) begin errors++; $display("FAIL wr1_cs_low: got %0d expected %0d", csl, exp_cs_low(1, 1'b1)); end
        checks++; if (bc !== csl + 1) begin errors++; $display("FAIL wr1_busy_len: got %0d expected %0d", bc, csl + 1); end
        checks++; if (np !== 1) begin errors++; $display("FAIL wr1_rsp_pulses: got %0d expected 1", np); end
        checks++; if (rd !== exp_rd[0]) begin errors++; $display("FAIL wr1_rdata_hold: got %h expected %h", rd, exp_rd[0]); end
    endtask

    task automatic test_read_div2();
        logic [23:0] obs; int nb, csl, bc, np; logic [7:0] rd; bit to;
        sel = 2'd1;
        slv_word = 24'hFFFF3C;
        run_xfer(1'b0, 1'b1, 6'h10, 8'h77, obs, nb, csl, bc, np, rd, to);
        exp_rd[1] = slv_word[7:0];
        checks++; if (to) begin errors++; $display("FAIL rd2_timeout: rsp_valid not seen within 400 cycles"); end
        checks++; if (nb !== 24 || obs !== exp_stream(1'b0, 1'b1, 6'h10, 8'h77)) begin
            errors++; $display("FAIL rd2_mosi: got %0d bits %h expected 24 bits %h", nb, obs, exp_stream(1'b0, 1'b1, 6'h10, 8'h77));
        end
        checks++; if (rd !== exp_rd[1]) begin errors++; $display("FAIL rd2_rdata: got %h expected %h", rd, exp_rd[1]); end
        checks++; if (csl !== exp_cs_low(2, 1'b0)) begin errors++; $display("FAIL rd2_cs_low: got %0d expected %0d", csl, exp_cs_low(2, 1'b0)); end
        checks++; if (np !== 1) begin errors++; $display("FAIL rd2_rsp_pulses: got %0d expected 1", np); end
    endtask

    task automatic test_back_to_back();
        logic [5:0] aa, ab; logic [7:0] wa, wb, rd; logic ha, hb; bit to1, to2;
        logic [23:0] oa, ob; int b0, f0, r0, p0, e0, gap;
        sel = 2'd3;
        aa = 6'($urandom); ab = 6'($urandom); wa = 8'($urandom); wb = 8'($urandom);
        ha = 1'($urandom); hb = 1'($urandom);
        b0 = mosi_bits.size(); f0 = cs_fall_t.size(); r0 = cs_rise_t.size(); p0 = rsp_cnt; e0 = rdy_busy_err;
        req_valid = 1'b1; req_write = 1'b1; req_hl = ha; req_addr = aa; req_wdata = wa;
        @(negedge clk);
        req_hl = hb; req_addr = ab; req_wdata = wb;
        wait_rsp(rd, to1);
        @(negedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        req_hl = 1'($urandom); req_addr = 6'($urandom); req_wdata = 8'($urandom);
        wait_rsp(rd, to2);
        @(negedge clk);
        @(negedge clk);
        oa = '0; ob = '0;
        for (int i = 0; i < 16; i++) begin
            oa = {oa[22:0], mosi_bits[b0 + i]};
            ob = {ob[22:0], mosi_bits[b0 + 16 + i]};
        end
        gap = cs_fall_t[f0 + 1] - cs_rise_t[r0];
        checks++; if (to1 || to2) begin errors++; $display("FAIL b2b_timeout: got timeouts %0d/%0d expected none", to1, to2); end
        checks++; if (oa !== exp_stream(1'b1, ha, aa, wa)) begin errors++; $display("FAIL b2b_first: got %h expected %h", oa, exp_stream(1'b1, ha, aa, wa)); end
        checks++; if (ob !== exp_stream(1'b1, hb, ab, wb)) begin errors++; $display("FAIL b2b_second: got %h expected %h", ob, exp_stream(1'b1, hb, ab, wb)); end
        checks++; if (mosi_bits.size() - b0 !== 32) begin errors++; $display("FAIL b2b_bits: got %0d expected 32", mosi_bits.size() - b0); end
        checks++; if (rsp_cnt - p0 !== 2) begin errors++; $display("FAIL b2b_rsp_pulses: got %0d expected 2", rsp_cnt - p0); end
        checks++; if (cs_fall_t.size() - f0 !== 2) begin errors++; $display("FAIL b2b_cs_count: got %0d expected 2", cs_fall_t.size() - f0); end
        checks++; if (gap < 2) begin errors++; $display("FAIL b2b_cs_gap: got %0d expected >=2", gap); end
        checks++; if (rdy_busy_err !== e0) begin errors++; $display("FAIL b2b_ready_while_busy: got %0d expected %0d", rdy_busy_err, e0); end
    endtask

    task automatic test_reset_mid();
        logic [23:0] obs; int nb, csl, bc, np, b0, p0, n; logic [7:0] rd, wd; logic [5:0] a; bit to;
        sel = 2'd2;
        b0 = mosi_bits.size(); p0 = rsp_cnt;
        req_valid = 1'b1; req_write = 1'b1; req_hl = 1'($urandom); req_addr = 6'($urandom); req_wdata = 8'($urandom);
        @(negedge clk);
        req_valid = 1'b0;
        n = 0;
        while (mosi_bits.size() - b0 < 13 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        checks++; if (n >= 1000) begin errors++; $display("FAIL rstmid_reach: got %0d bits expected 13", mosi_bits.size() - b0); end
        rst_n = 1'b0;
        #1;
        checks++; if (csn_v !== 4'hF) begin errors++; $display("FAIL rstmid_cs_n: got %b expected 1111", csn_v); end
        checks++; if (sclk_v !== 4'h0) begin errors++; $display("FAIL rstmid_sclk: got %b expected 0000", sclk_v); end
        checks++; if (mosi_v !== 4'h0) begin errors++; $display("FAIL rstmid_mosi: got %b expected 0000", mosi_v); end
        checks++; if (rspv_v !== 4'h0) begin errors++; $display("FAIL rstmid_rsp_valid: got %b expected 0000", rspv_v); end
        checks++; if (busy_v !== 4'h0 || rdy_v !== 4'hF) begin errors++; $display("FAIL rstmid_busy_ready: got %b/%b expected 0000/1111", busy_v, rdy_v); end
        for (int i = 0; i < 4; i++) exp_rd[i] = 8'h00;
        checks++; if (rdata_v[1] !== exp_rd[1]) begin errors++; $display("FAIL rstmid_rdata: got %h expected %h", rdata_v[1], exp_rd[1]); end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (rsp_cnt !== p0) begin errors++; $display("FAIL rstmid_no_rsp: got %0d pulses expected 0", rsp_cnt - p0); end
        a = 6'($urandom); wd = 8'($urandom);
        run_xfer(1'b1, 1'b0, a, wd, obs, nb, csl, bc, np, rd, to);
        checks++; if (to || obs !== exp_stream(1'b1, 1'b0, a, wd)) begin errors++; $display("FAIL rstmid_after_mosi: got %h expected %h", obs, exp_stream(1'b1, 1'b0, a, wd)); end
        checks++; if (np !== 1 || csl !== exp_cs_low(3, 1'b1)) begin errors++; $display("FAIL rstmid_after_len: got %0d pulses %0d cs-low expected 1 %0d", np, csl, exp_cs_low(3, 1'b1)); end
    endtask

    task automatic test_loopback();
        logic [23:0] obs; int nb, csl, bc, np, rt0, h0, m0, n6, nd, bad_hi; logic [7:0] rd; bit to;
        sel = 2'd2;
        loop_en = 1'b1;
        rt0 = rise_t.size(); h0 = hi_lens.size(); m0 = mode0_err;
        run_xfer(1'b0, 1'b0, 6'h2A, 8'($urandom), obs, nb, csl, bc, np, rd, to);
        loop_en = 1'b0;
        exp_rd[2] = 8'h00;
        n6 = 0; nd = 0; bad_hi = 0;
        for (int i = rt0 + 1; i < rise_t.size(); i++) begin
            nd++;
            if (rise_t[i] - rise_t[i - 1] == 6) n6++;
        end
        for (int i = h0; i < hi_lens.size(); i++) if (hi_lens[i] != 3) bad_hi++;
        checks++; if (to || obs !== exp_stream(1'b0, 1'b0, 6'h2A, 8'h00)) begin errors++; $display("FAIL loop_mosi: got %h expected %h", obs, exp_stream(1'b0, 1'b0, 6'h2A, 8'h00)); end
        checks++; if (rd !== exp_rd[2]) begin errors++; $display("FAIL loop_rdata: got %h expected %h", rd, exp_rd[2]); end
        checks++; if (csl !== exp_cs_low(3, 1'b0)) begin errors++; $display("FAIL loop_cs_low: got %0d expected %0d", csl, exp_cs_low(3, 1'b0)); end
        checks++; if (nd !== 23 || n6 !== 21) begin errors++; $display("FAIL loop_sclk_period: got %0d of %0d periods of 6 expected 21 of 23", n6, nd); end
        checks++; if (bad_hi !== 0 || hi_lens.size() - h0 !== 24) begin errors++; $display("FAIL loop_sclk_high: got %0d bad of %0d expected 0 of 24", bad_hi, hi_lens.size() - h0); end
        checks++; if (mode0_err !== m0) begin errors++; $display("FAIL loop_mode0: got %0d edge violations expected 0", mode0_err - m0); end
    endtask

    task automatic test_random();
        logic [23:0] obs; int nb, csl, bc, np; logic [7:0] rd, wd; logic [5:0] a; logic wr, hl; bit to;
        for (int it = 0; it < 10; it++) begin
            sel = 2'($urandom);
            wr = 1'($urandom); hl = 1'($urandom); a = 6'($urandom); wd = 8'($urandom);
            slv_word = 24'($urandom);
            run_xfer(wr, hl, a, wd, obs, nb, csl, bc, np, rd, to);
            if (!wr) exp_rd[sel] = slv_word[7:0];
            checks++; if (to || obs !== exp_stream(wr, hl, a, wd) || nb !== (wr ? 16 : 24)) begin
                errors++; $display("FAIL rand_mosi[%0d]: got %0d bits %h expected %h", it, nb, obs, exp_stream(wr, hl, a, wd));
            end
            checks++; if (csl !== exp_cs_low(int'(sel) + 1, wr)) begin errors++; $display("FAIL rand_cs_low[%0d]: got %0d expected %0d", it, csl, exp_cs_low(int'(sel) + 1, wr)); end
            checks++; if (np !== 1) begin errors++; $display("FAIL rand_rsp_pulses[%0d]: got %0d expected 1", it, np); end
            checks++; if (rd !== exp_rd[sel]) begin errors++; $display("FAIL rand_rdata[%0d]: got %h expected %h", it, rd, exp_rd[sel]); end
        end
        checks++; if (rdy_busy_err !== 0) begin errors++; $display("FAIL ready_busy_overlap: got %0d cycles expected 0", rdy_busy_err); end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation still running at 2 ms");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        req_valid = 1'b0; req_write = 1'b0; req_hl = 1'b0; req_addr = '0; req_wdata = '0;
        loop_en = 1'b0; sel = 2'd0; slv_word = '0; slv_cnt = 0;
        for (int i = 0; i < 4; i++) exp_rd[i] = 8'h00;
        repeat (3) @(negedge clk);
        test_reset();
        test_write_div1();
        test_read_div2();
        test_back_to_back();
        test_reset_mid();
        test_loopback();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
